wb_commit_unit: RTL

- Writeback-side consumer of the four EXE/WB lanes (alu, ld, mul, div).
- Buffers each lane's result in a small per-lane FIFO and drains them into the register file through its single write port, one write per cycle, using round-robin arbitration.
- Exports per-lane ready, which drives the EXE/WB per-lane write-allow, and a pending-destination mask used by issue-stage hazard detection.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_lane_fifo.sv | 82 ++++++++
 rtl/wb_commit_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback commit unit.
// Lane indices match the bit order of the EXE/WB lane buses.
package wb_pkg;

  localparam int NLANES   = 4;
  localparam int LANE_DIV = 0;
  localparam int LANE_MUL = 1;
  localparam int LANE_LD  = 2;
  localparam int LANE_ALU = 3;

  localparam int RD_W   = 4;
  localparam int NREG_C = 16;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NREG_C-1:0] rd_onehot(input logic [RD_W-1:0] rd);
    rd_onehot = NREG_C'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_lane_fifo.sv
// Per-lane circular result buffer; exposes per-entry occupancy and Rd
// so the top can build the pending-destination mask.
module wb_lane_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  wb_entry_t                  push_entry_i,
  input  logic                       pop_i,
  output wb_entry_t                  head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [CW-1:0]              count_o,
  output logic [DEPTH-1:0]           ent_valid_o,
  output logic [DEPTH-1:0][RD_W-1:0] ent_rd_o
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  wb_entry_t     mem_q [DEPTH];

  logic do_push;
  logic do_pop;
  logic [AW-1:0] offs;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // Slot j is live when its distance from the read pointer is below count.
  always_comb begin
    offs        = '0;
    ent_valid_o = '0;
    ent_rd_o    = '0;
    for (int j = 0; j < DEPTH; j++) begin
      offs           = AW'(j) - rd_ptr_q;
      ent_valid_o[j] = ({1'b0, offs} < count_q);
      ent_rd_o[j]    = mem_q[j].rd;
    end
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Buffers the four EXE/WB lanes and drains them into the single register-file
// write port with round-robin arbitration; also exports pending destinations.
module wb_commit_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NREG  = 16,
  parameter int DW    = 32,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NLANES-1:0]           lane_valid,
  input  logic [NLANES-1:0][RD_W-1:0] lane_rd,
  input  logic [NLANES-1:0][DW-1:0]   lane_data,
  output logic [NLANES-1:0]           lane_ready,
  output logic                        rf_we,
  output logic [RD_W-1:0]             rf_wa,
  output logic [DW-1:0]               rf_wd,
  output logic [NREG-1:0]             pending_mask,
  output logic                        busy
);

  wb_entry_t                  head       [NLANES];
  logic [CW-1:0]              lane_count [NLANES];
  logic [DEPTH-1:0]           ent_valid  [NLANES];
  logic [DEPTH-1:0][RD_W-1:0] ent_rd     [NLANES];
  logic [NLANES-1:0]          lane_full;
  logic [NLANES-1:0]          lane_empty;
  logic [NLANES-1:0]          req;
  logic [NLANES-1:0]          pop;

  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic            rf_we_q,  rf_we_d;
  logic [RD_W-1:0] rf_wa_q,  rf_wa_d;
  logic [DW-1:0]   rf_wd_q,  rf_wd_d;

  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [1:0] scan_idx;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    wb_lane_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (lane_valid[i]),
      .push_entry_i ('{rd: lane_rd[i], data: lane_data[i]}),
      .pop_i        (pop[i]),
      .head_o       (head[i]),
      .full_o       (lane_full[i]),
      .empty_o      (lane_empty[i]),
      .count_o      (lane_count[i]),
      .ent_valid_o  (ent_valid[i]),
      .ent_rd_o     (ent_rd[i])
    );

    assign lane_ready[i] = ~lane_full[i];
    assign req[i]        = (lane_count[i] != '0);
    assign pop[i]        = gnt_valid && (gnt_idx == 2'(i));
  end

  // First requester at or after rr_ptr, wrapping modulo four.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = rr_ptr_q;
    scan_idx  = '0;
    for (int k = 0; k < NLANES; k++) begin
      scan_idx = rr_ptr_q + 2'(k);
      if (!gnt_valid && req[scan_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    rf_we_d  = 1'b0;
    rf_wa_d  = rf_wa_q;
    rf_wd_d  = rf_wd_q;
    if (gnt_valid) begin
      rf_we_d  = 1'b1;
      rf_wa_d  = head[gnt_idx].rd;
      rf_wd_d  = head[gnt_idx].data;
      rr_ptr_d = gnt_idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      rf_we_q  <= 1'b0;
      rf_wa_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rf_we_q  <= rf_we_d;
      rf_wa_q  <= rf_wa_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;

  // Buffered entries plus the entry currently being written are all in flight.
  always_comb begin
    pending_mask = rf_we_q ? rd_onehot(rf_wa_q) : '0;
    for (int i = 0; i < NLANES; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (ent_valid[i][j]) pending_mask = pending_mask | rd_onehot(ent_rd[i][j]);
      end
    end
  end

  assign busy = (~&lane_empty) | rf_we_q;

endmodule
